// File: rtl/mem_pkg.sv
// mem_pkg: shared load-op encodings, tracker entry type and parameter checks
package mem_pkg;
   localparam int LD_B  = 0;
   localparam int LD_H  = 1;
   localparam int LD_W  = 2;
   localparam int LD_BU = 3;
   localparam int LD_HU = 4;
   localparam int OP_W  = 5;

   // Per-entry control bits; offset and data live in width-parameterised arrays
   typedef struct packed {
      logic            we;
      logic [OP_W-1:0] load_op;
      logic            filled;
      logic            cancelled;
   } entry_t;

   function automatic bit depth_ok(input int d);
      return d >= 2 && d <= 16 && (d & (d - 1)) == 0;
   endfunction
endpackage

// File: rtl/load_align.sv
// load_align: extracts a byte/half/word lane from DATA_W bus data and sign/zero extends it
module load_align
   import mem_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic [OFF_W-1:0]  offset_i,
   output logic [DATA_W-1:0] data_o
);
   logic [OFF_W+2:0] bit_idx;
   logic [7:0]       b;
   logic [15:0]      h;

   // Half lane reuses the byte bit index with its low half-select bit dropped
   always_comb begin
      bit_idx = {offset_i, 3'b000};
      b = data_i[bit_idx +: 8];
      h = data_i[{bit_idx[OFF_W+2:4], 4'b0000} +: 16];
      data_o = op_i[LD_B]  ? {{(DATA_W-8){b[7]}}, b} :
               op_i[LD_BU] ? {{(DATA_W-8){1'b0}}, b} :
               op_i[LD_H]  ? {{(DATA_W-16){h[15]}}, h} :
               op_i[LD_HU] ? {{(DATA_W-16){1'b0}}, h} :
               op_i[LD_W]  ? data_i : '0;
   end
endmodule

// File: rtl/mem_resp_tracker.sv
// mem_resp_tracker: in-order tracker of outstanding data-bus requests with flush cancellation
module mem_resp_tracker
   import mem_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 32,
   localparam int OFF_W  = $clog2(DATA_W / 8),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [OP_W-1:0]   req_load_op,
   input  logic [OFF_W-1:0]  req_offset,
   input  logic              data_sram_data_ok,
   input  logic [DATA_W-1:0] data_sram_rdata,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_is_store,
   output logic [CNT_W-1:0]  outstanding,
   output logic              err_spurious
);
   localparam int PW = $clog2(DEPTH);

   if (!depth_ok(DEPTH) || (DATA_W != 32 && DATA_W != 64)) begin : g_bad_param
      $error("mem_resp_tracker: DEPTH must be a power of two in 2..16 and DATA_W 32 or 64");
   end

   entry_t            ent_q[DEPTH], ent_d[DEPTH];
   logic [DATA_W-1:0] dat_q[DEPTH], dat_d[DEPTH];
   logic [OFF_W-1:0]  off_q[DEPTH], off_d[DEPTH];
   logic [PW-1:0]     tail_q, tail_d, fill_q, fill_d, head_q, head_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              err_q, err_d;
   logic              full, alloc, has_unfilled, fill_en, head_busy, pop;
   entry_t            head;
   logic [DATA_W-1:0] aligned;

   load_align #(.DATA_W(DATA_W)) u_align (
      .data_i   (dat_q[head_q]),
      .op_i     (head.load_op),
      .offset_i (off_q[head_q]),
      .data_o   (aligned)
   );

   // Allocate at tail, fill at fill pointer, retire at head; flush marks every entry cancelled
   always_comb begin
      ent_d = ent_q;
      dat_d = dat_q;
      off_d = off_q;
      full = count_q == CNT_W'(DEPTH);
      req_ready = !full;
      alloc = req_valid && !full;
      has_unfilled = fill_q != tail_q || (full && !ent_q[fill_q].filled);
      fill_en = data_sram_data_ok && has_unfilled;
      head = ent_q[head_q];
      head_busy = count_q != '0;
      out_valid = head_busy && head.filled && !head.cancelled && !flush;
      pop = (out_valid && out_ready) || (head_busy && head.filled && head.cancelled);
      out_data = (out_valid && !head.we) ? aligned : '0;
      out_is_store = out_valid && head.we;
      if (flush) for (int i = 0; i < DEPTH; i++) ent_d[i].cancelled = 1'b1;
      if (fill_en) begin
         ent_d[fill_q].filled = 1'b1;
         dat_d[fill_q] = data_sram_rdata;
      end
      if (alloc) begin
         ent_d[tail_q] = '{we: req_we, load_op: req_load_op, filled: 1'b0, cancelled: flush};
         off_d[tail_q] = req_offset;
      end
      tail_d = tail_q + PW'(alloc);
      fill_d = fill_q + PW'(fill_en);
      head_d = head_q + PW'(pop);
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
      err_d = err_q | (data_sram_data_ok && !has_unfilled);
      outstanding = count_q;
      err_spurious = err_q;
   end

   // State registers; reset clears pointers, count, sticky error and every entry
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tail_q  <= '0;
         fill_q  <= '0;
         head_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
            dat_q[i] <= '0;
            off_q[i] <= '0;
         end
      end else begin
         tail_q  <= tail_d;
         fill_q  <= fill_d;
         head_q  <= head_d;
         count_q <= count_d;
         err_q   <= err_d;
         ent_q   <= ent_d;
         dat_q   <= dat_d;
         off_q   <= off_d;
      end
   end
endmodule

// File: tb/tb_mem_resp_tracker.sv
// tb_mem_resp_tracker: scoreboard bench for the memory response tracker
module tb_mem_resp_tracker;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [4:0]  req_load_op = '0;
   logic [1:0]  req_offset = '0;
   logic        data_ok = 1'b0;
   logic [31:0] rdata = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_is_store;
   logic [2:0]  outstanding;
   logic        err_spurious;

   typedef struct {
      logic       we;
      logic [4:0] op;
      logic [1:0] off;
      logic       canc;
   } pend_t;

   pend_t       pend_q[$];
   logic [32:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   bit          skip_alloc = 1'b0;

   localparam logic [4:0] OP_B = 5'b00001, OP_H = 5'b00010, OP_W = 5'b00100, OP_BU = 5'b01000, OP_HU = 5'b10000;

   mem_resp_tracker #(.DEPTH(4), .DATA_W(32)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_we            (req_we),
      .req_load_op       (req_load_op),
      .req_offset        (req_offset),
      .data_sram_data_ok (data_ok),
      .data_sram_rdata   (rdata),
      .flush             (flush),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_is_store      (out_is_store),
      .outstanding       (outstanding),
      .err_spurious      (err_spurious)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] align_ref(input logic [4:0] op, input logic [1:0] off, input logic [31:0] d);
      logic [31:0] sb, sh;
      sb = d >> (8 * off);
      sh = d >> (16 * off[1]);
      if (op[0]) return {{24{sb[7]}}, sb[7:0]};
      if (op[3]) return {24'h0, sb[7:0]};
      if (op[1]) return {{16{sh[15]}}, sh[15:0]};
      if (op[4]) return {16'h0, sh[15:0]};
      if (op[2]) return d;
      return 32'h0;
   endfunction

   // Scoreboard: every presented result must match the oldest expected one; handshakes retire it
   always @(negedge clk) begin
      if (resetn && out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result got store=%b data=%h required no result", out_is_store, out_data);
         end else begin
            if ({out_is_store, out_data} !== exp_q[0]) begin
               errors++;
               $display("FAIL scoreboard got store=%b data=%h required store=%b data=%h",
                        out_is_store, out_data, exp_q[0][32], exp_q[0][31:0]);
            end
            if (out_ready) begin
               void'(exp_q.pop_front());
               pops++;
            end
         end
      end
   end

   task automatic cyc();
      pend_t p;
      if (flush) begin
         foreach (pend_q[i]) pend_q[i].canc = 1'b1;
         exp_q.delete();
      end
      if (data_ok && pend_q.size() > 0) begin
         p = pend_q.pop_front();
         if (!p.canc) exp_q.push_back({p.we, p.we ? 32'h0 : align_ref(p.op, p.off, rdata)});
      end
      if (req_valid && !skip_alloc) pend_q.push_back('{req_we, req_load_op, req_offset, flush});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we = 1'b0;
      data_ok = 1'b0;
      flush = 1'b0;
      skip_alloc = 1'b0;
   endtask

   task automatic req(input logic we, input logic [4:0] op, input logic [1:0] off);
      req_valid = 1'b1;
      req_we = we;
      req_load_op = op;
      req_offset = off;
   endtask

   task automatic resp(input logic [31:0] d);
      data_ok = 1'b1;
      rdata = d;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (out_is_store !== 1'b0) begin errors++; $display("FAIL reset_out_is_store got %b want 0", out_is_store); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
      checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_spurious); end
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_load();
      out_ready = 1'b1;
      req(1'b0, OP_B, 2'd3); cyc();
      resp(32'h80FF_1234); cyc();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid got %b want 1", out_valid); end
      checks++; if (out_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_data got %h want ffffff80", out_data); end
      cyc();
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL ldb_drained got %0d want 0", outstanding); end
      req(1'b0, OP_BU, 2'd3); cyc();
      resp(32'h80FF_1234); cyc();
      checks++; if (out_data !== 32'h0000_0080) begin errors++; $display("FAIL ldbu_data got %h want 00000080", out_data); end
      cyc();
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = pops;
      out_ready = 1'b0;
      req(1'b0, OP_W, 2'd0); cyc();
      req(1'b0, OP_H, 2'd2); cyc();
      req(1'b0, OP_HU, 2'd0); cyc();
      req(1'b1, OP_W, 2'd0); cyc();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready got %b want 0", req_ready); end
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding got %0d want 4", outstanding); end
      resp(32'h1234_8765); cyc();
      resp(32'hA5C3_7F01); cyc();
      resp(32'h0000_BEEF); cyc();
      resp(32'hDEAD_BEEF); cyc();
      cyc();
      checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL stalled_outstanding got %0d want 4", outstanding); end
      checks++; if (out_data !== 32'h1234_8765) begin errors++; $display("FAIL stalled_head got %h want 12348765", out_data); end
      out_ready = 1'b1;
      req(1'b0, OP_W, 2'd0);
      skip_alloc = 1'b1;
      cyc();
      checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL pop_at_full got %0d want 3", outstanding); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got %b want 1", req_ready); end
      repeat (3) cyc();
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL b2b_drained got %0d want 0", outstanding); end
      checks++; if (pops - p0 !== 4) begin errors++; $display("FAIL b2b_pops got %0d want 4", pops - p0); end
   endtask

   task automatic test_flush();
      int p0;
      p0 = pops;
      out_ready = 1'b1;
      req(1'b0, OP_W, 2'd0); cyc();
      req(1'b0, OP_W, 2'd0); cyc();
      flush = 1'b1; cyc();
      req(1'b0, OP_H, 2'd0); cyc();
      resp(32'h1111_1111); cyc();
      resp(32'h2222_2222); cyc();
      resp(32'h0000_8001); cyc();
      checks++; if (out_data !== 32'hFFFF_8001) begin errors++; $display("FAIL flush_survivor got %h want ffff8001", out_data); end
      repeat (2) cyc();
      checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL flush_pops got %0d want 1", pops - p0); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL flush_drained got %0d want 0", outstanding); end
   endtask

   task automatic test_flush_alloc();
      int p0;
      p0 = pops;
      req(1'b0, OP_W, 2'd0);
      flush = 1'b1;
      cyc();
      checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL flush_alloc_count got %0d want 1", outstanding); end
      resp(32'hCAFE_F00D); cyc();
      repeat (2) cyc();
      checks++; if (pops !== p0) begin errors++; $display("FAIL flush_alloc_pops got %0d want %0d", pops, p0); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL flush_alloc_drained got %0d want 0", outstanding); end
   endtask

   task automatic test_spurious_reset();
      checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL err_clean got %b want 0", err_spurious); end
      resp(32'h5); cyc();
      checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err_spurious); end
      repeat (2) cyc();
      checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_spurious); end
      out_ready = 1'b0;
      req(1'b0, OP_W, 2'd0); cyc();
      resp(32'h77); cyc();
      req(1'b0, OP_W, 2'd0); cyc();
      checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL pre_reset_count got %0d want 2", outstanding); end
      #2;
      resetn = 1'b0;
      pend_q.delete();
      exp_q.delete();
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_req_ready got %b want 1", req_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL mid_reset_out_data got %h want 0", out_data); end
      checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_reset_outstanding got %0d want 0", outstanding); end
      checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL mid_reset_err got %b want 0", err_spurious); end
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      resp(32'h99); cyc();
      checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL late_data_ok_err got %b want 1", err_spurious); end
   endtask

   initial begin
      test_reset();
      test_single_load();
      test_back_to_back();
      test_flush();
      test_flush_alloc();
      test_spurious_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule

// File: doc/mem_resp_tracker.md
Name: mem_resp_tracker

Overview:
- Memory-stage response tracker that replaces the single-outstanding load/store wait in the MEM stage.
- Tracks up to DEPTH outstanding data-bus requests in issue order.
- Captures each data_ok response into its entry; data_ok is never back-pressured.
- Performs load byte/half alignment with sign/zero extension and hands results to WB through a valid/ready handshake.
- On a pipeline flush, discards responses belonging to cancelled requests.

Parameters:
- DEPTH, 4, maximum outstanding requests; power of two, 2..16.
- DATA_W, 32, data bus width; 32 or 64.
- OFF_W, $clog2(DATA_W/8), byte-offset width; derived, not overridden.
- CNT_W, $clog2(DEPTH+1), width of the outstanding count.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request accepted by the data bus this cycle (addr_ok handshake done).
- req_ready  out  1  a tracker entry is free.
- req_we  in  1  request is a store.
- req_load_op  in  5  one-hot: [0] ld.b, [1] ld.h, [2] ld.w (full DATA_W), [3] ld.bu, [4] ld.hu.
- req_offset  in  OFF_W  address low bits.
- data_sram_data_ok  in  1  response for the oldest unfilled request.
- data_sram_rdata  in  DATA_W  response data.
- flush  in  1  exception/ertn/refetch flush from WB.
- out_valid  out  1  head result available.
- out_ready  in  1  WB accepts the result.
- out_data  out  DATA_W  aligned and extended load data; 0 for stores.
- out_is_store  out  1  head entry was a store.
- outstanding  out  CNT_W  number of allocated entries.
- err_spurious  out  1  sticky: data_ok arrived with no unfilled entry.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries, each holding {we, load_op, offset, filled, cancelled, data}.
  - Three pointers: tail (allocate), fill (next entry to receive data_ok), head (retire).
  - One count register.
- Reset (asynchronous, resetn=0):
  - All pointers and count are 0; all entries are invalid.
  - req_ready=1, out_valid=0, out_data=0, out_is_store=0, outstanding=0, err_spurious=0.
- Allocate:
  - Occurs when req_valid && req_ready. The entry at tail gets filled=0, and cancelled=flush for that same cycle.
  - tail advances and wraps modulo DEPTH.
  - req_ready = (count != DEPTH), computed from registered count only. A pop in the same cycle does not free a slot for allocation at full.
- Fill:
  - On data_sram_data_ok with fill != tail (or count==DEPTH with all entries unfilled): entry[fill].data <= rdata, filled <= 1, fill advances.
  - With no unfilled entry, the response is dropped and err_spurious <= 1 (sticky until reset).
  - Fill and allocate may target the same entry index only if it is already allocated. A request allocated this cycle is not fillable until the next cycle (zero-cycle data_ok is illegal on the bus).
- Retire:
  - head entry filled && !cancelled: out_valid=1 unless flush=1. The pop occurs on out_valid && out_ready.
  - head entry filled && cancelled: silent pop, one per cycle, out_valid=0.
  - head unfilled: out_valid=0.
  - out_valid, out_data and out_is_store are combinational from the head entry. Latency from data_ok to out_valid is 1 cycle.
- Flush:
  - All allocated entries get cancelled <= 1.
  - Filled-cancelled entries drain silently at head. Unfilled-cancelled entries still consume their data_ok, then drain.
  - count is not reset by flush.
  - Flush with data_ok in the same cycle: data is written and the entry is cancelled.
- Count:
  - count += alloc - pop; both may happen in one cycle.
  - outstanding = count.
- Alignment:
  - byte lane = offset; half lane = offset[OFF_W-1:1].
  - Sign-extend for op[0]/op[1], zero-extend for op[3]/op[4], op[2] passes full DATA_W.
  - Stores give out_data=0.
  - Misaligned half offsets (offset[0]=1) never reach the tracker; behaviour for them is unspecified.
- Mid-operation reset: all state clears immediately. Late data_ok after reset sets err_spurious.

Decomposition:
- Package mem_pkg:
  - load_op bit index constants (LD_B, LD_H, LD_W, LD_BU, LD_HU).
  - Entry struct typedef.
  - DEPTH range check.
- One sub-module: load_align (combinational DATA_W extractor/extender), reused by the future cache refill path.

Test Plan:
- Reset, then 1 load: ld.b offset 3, rdata 0x80FF_1234 one cycle later -> next cycle out_valid=1, out_data=0xFFFF_FF80; ld.bu on the same data -> 0x0000_0080.
- Four back-to-back loads with DEPTH=4 -> req_ready=0 after the 4th. A pop and a req_valid in the same cycle at full -> no allocation; req_ready=1 the next cycle.
- Responses arriving while out_ready=0 for 5 cycles -> all four stored; then out_ready=1 pops them in order, one per cycle, with correct data.
- Two loads outstanding, flush, then 1 new load; three data_ok -> first two silently dropped; only the third gives out_valid; outstanding returns to 0.
- Flush in the same cycle as req_valid -> that entry is cancelled and its response is never presented.
- data_ok with outstanding=0 -> err_spurious=1 and stays set; assert resetn=0 mid-stream -> all outputs return to reset values immediately.
